// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port-A arbiter: default widths, read-owner
// encoding and the read-tracking pipeline entry.
package ram_arb_pkg;

   localparam int RAM_ADDR_W = 14;
   localparam int RAM_DATA_W = 8;

   typedef enum logic {
      OWN_Z80 = 1'b0,
      OWN_ESP = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } trk_entry_t;

endpackage

// File: rtl/ram_rd_track.sv
// Follows each accepted access through the RAM's two-stage read pipeline.
// It produces the output-register enable, the per-requester return strobes and busy.
module ram_rd_track
   import ram_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_push_rd,
   input  owner_e i_push_owner,
   input  logic   i_cea,
   output logic   o_ocea,
   output logic   o_rvalid0,
   output logic   o_rvalid1,
   output logic   o_busy
);

   // Stage 0 is the cea cycle, stage 1 the ocea cycle, stage 2 the return cycle.
   trk_entry_t [2:0] r_stage;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // shifts from the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= '{valid: i_push_rd, owner: i_push_owner};
         r_stage[1] <= r_stage[0];
         r_stage[2] <= r_stage[1];
      end
   end

   assign o_ocea    = r_stage[1].valid;
   assign o_rvalid0 = r_stage[2].valid && (r_stage[2].owner == OWN_Z80);
   assign o_rvalid1 = r_stage[2].valid && (r_stage[2].owner == OWN_ESP);
   // Writes never enter the tracker, so their single busy cycle comes from cea.
   assign o_busy    = i_cea || r_stage[1].valid || r_stage[2].valid;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between the Z80 requester (priority) and the ESP loader,
// with a starvation guard, registered RAM controls and owner-routed read returns.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W     = RAM_ADDR_W,
   parameter int DATA_W     = RAM_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              ram_cea,
   output logic              ram_ocea,
   output logic              ram_wrea,
   output logic [ADDR_W-1:0] ram_ada,
   output logic [DATA_W-1:0] ram_dina,
   input  logic [DATA_W-1:0] ram_douta,
   output logic              busy
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]  r_starve_cnt;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_acc;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   owner_e            w_owner;
   logic              w_rvalid0;
   logic              w_rvalid1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   // ESP wins when it has waited out STARVE_MAX Z80 grants or the Z80 is idle.
   assign w_gnt1  = req1_valid && ((r_starve_cnt == STARVE_LIM) || !req0_valid);
   assign w_gnt0  = req0_valid && !w_gnt1;
   assign w_acc   = w_gnt0 || w_gnt1;
   assign w_we    = w_gnt1 ? req1_we    : req0_we;
   assign w_addr  = w_gnt1 ? req1_addr  : req0_addr;
   assign w_wdata = w_gnt1 ? req1_wdata : req0_wdata;
   assign w_owner = w_gnt1 ? OWN_ESP    : OWN_Z80;

   // Grants are combinational, so they are masked to keep ready low during reset.
   assign req0_ready = w_gnt0 && rst_n;
   assign req1_ready = w_gnt1 && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (!req1_valid || w_gnt1) begin
         r_starve_cnt <= '0;
      end else if (w_gnt0 && (r_starve_cnt != STARVE_LIM)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_cea  <= 1'b0;
         ram_wrea <= 1'b0;
         ram_ada  <= '0;
         ram_dina <= '0;
      end else begin
         ram_cea  <= w_acc;
         ram_wrea <= w_acc && w_we;
         if (w_acc) begin
            ram_ada  <= w_addr;
            ram_dina <= w_wdata;
         end
      end
   end

   ram_rd_track u_rd_track (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push_rd    (w_acc && !w_we),
      .i_push_owner (w_owner),
      .i_cea        (ram_cea),
      .o_ocea       (ram_ocea),
      .o_rvalid0    (w_rvalid0),
      .o_rvalid1    (w_rvalid1),
      .o_busy       (busy)
   );

   // Return data comes straight from the RAM register; the hold copy keeps
   // the non-owner's rdata stable between its own returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_rvalid0) r_rdata0 <= ram_douta;
         if (w_rvalid1) r_rdata1 <= ram_douta;
      end
   end

   assign req0_rvalid = w_rvalid0;
   assign req1_rvalid = w_rvalid1;
   assign req0_rdata  = w_rvalid0 ? ram_douta : r_rdata0;
   assign req1_rdata  = w_rvalid1 ? ram_douta : r_rdata1;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single read/write port A of the 16K x 8 dual-port block RAM between two requesters: requester 0 (Z80 bus side, latency-critical) and requester 1 (ESP loader side, bulk). It arbitrates with priority plus a starvation guard, registers the RAM control and address/data, and tracks in-flight reads through the two-stage pipelined RAM read path. It returns each read result to the requester that issued it. Port B of the RAM is untouched.

## Interface
Parameters:
- ADDR_W, 14, RAM address width (16384 locations)
- DATA_W, 8, data width
- STARVE_MAX, 4, consecutive requester-0 grants allowed while requester 1 waits

Ports:
- clk  in  1  single clock; also drives RAM clka
- rst_n  in  1  asynchronous, active-low reset
- Requester 0 and requester 1 each have the same port set, named with prefix reqN_ (N = 0 or 1):
  - reqN_valid  in  1  request present
  - reqN_we  in  1  1 = write, 0 = read
  - reqN_addr  in  ADDR_W  address
  - reqN_wdata  in  DATA_W  write data
  - reqN_ready  out  1  grant; transfer occurs on an edge where valid and ready are both 1
  - reqN_rvalid  out  1  one-cycle pulse when read data is returned
  - reqN_rdata  out  DATA_W  read data, valid while reqN_rvalid is 1
- ram_cea  out  1  RAM port A clock enable
- ram_ocea  out  1  RAM port A output-register enable
- ram_wrea  out  1  RAM port A write enable
- ram_ada  out  ADDR_W  RAM port A address
- ram_dina  out  DATA_W  RAM port A write data
- ram_douta  in  DATA_W  RAM port A read data (pipelined output)
- busy  out  1  at least one access in flight

## Operation
- Accept stage (combinational grant, evaluated each cycle):
  - Requester 1 is granted if req1_valid is 1 and starve_cnt equals STARVE_MAX.
  - Otherwise requester 0 is granted if req0_valid is 1.
  - Otherwise requester 1 is granted if req1_valid is 1.
  - Exactly one reqN_ready is high in a cycle, or none. ready never rises without the matching valid.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each requester-0 grant while req1_valid is 1.
  - Clears on a requester-1 grant.
  - Clears when req1_valid is 0.
- Issue stage (registered): on acceptance, the next cycle drives ram_cea=1, ram_wrea=we, ram_ada=addr, ram_dina=wdata. Idle cycles drive ram_cea=0 and ram_wrea=0. ram_ada and ram_dina hold their last value.
- Read tracking: a 3-entry shift register of {valid, owner}, one entry per pipeline stage.
  - Only reads are entered; writes enter valid=0.
  - ram_ocea=1 in the cycle after a read's ram_cea cycle, and 0 otherwise.
- Return: in the cycle after the ocea cycle, ram_douta is routed to reqN_rdata of the owner, and reqN_rvalid pulses for 1 cycle. The non-owner's rdata holds its previous value.
- Ordering:
  - Accesses reach the RAM in grant order.
  - A read granted one cycle after a write to the same address returns the new data (write-mode normal; the write completes before the read's cea).
- Throughput: one access per cycle, reads and writes may be freely mixed, with no bubbles.
- No backpressure on read return: requesters must always accept rvalid.

## Timing
- Read granted at edge E0 (accept cycle C0):
  - C1: ram_cea=1.
  - C2: ram_ocea=1.
  - C3: reqN_rvalid=1 with data.
  - Latency is 3 cycles, accept edge to rvalid cycle.
- Write granted in C0: ram_cea=1 and ram_wrea=1 in C1. There is no response.
- busy: 1 from C1 through C3 of any read, and in C1 of a write.
- Reset values (async, on rst_n low):
  - All outputs 0: ram_cea, ram_ocea, ram_wrea, ram_ada, ram_dina, both ready, both rvalid, both rdata, busy.
  - starve_cnt = 0; tracking register cleared.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is produced after rst_n releases. The first grant is possible in the first cycle with rst_n high.
- Simultaneous valid from both requesters: requester 0 wins unless starve_cnt equals STARVE_MAX.

## Structure
- Shared package ram_arb_pkg: ADDR_W and DATA_W defaults, and an owner enum (OWN_Z80=0, OWN_ESP=1).
- One sub-module, ram_rd_track: the 3-stage {valid, owner} shift register. It outputs ram_ocea, the rvalid pulses, and busy.
- Arbiter logic and issue registers live in the top module.

## Test plan
- Single read: preload addr 0x1234=0xA5, req0 read 0x1234 -> ram_cea in C1, ram_ocea in C2, req0_rvalid in C3 with rdata=0xA5, req1_rvalid stays 0.
- Write then read: req1 write 0x3FFF=0x5A, then req1 read 0x3FFF on the next cycle -> rvalid 3 cycles after the read grant, rdata=0x5A.
- Starvation: req0 and req1 both valid continuously -> grant pattern 0,0,0,0,1 repeating (STARVE_MAX=4).
- Back-to-back mixed: alternate req0 reads and req1 reads of distinct preloaded addresses every cycle -> one rvalid per cycle, each routed to the correct owner with the correct data, in issue order.
- Reset mid-flight: assert rst_n low in C2 of a read -> all outputs 0 immediately, and no rvalid after release.
- Idle: both valid 0 for 10 cycles -> ram_cea=0, ram_wrea=0, busy=0, ready=0 throughout.
